// File: rtl/rotator_pkg.sv
// Shared types and reset constants for the rotator push-button front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rotator_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;

  // Power-up state of the rotator controls: paused, clockwise.
  localparam logic EN_RST = 1'b0;
  localparam logic CW_RST = 1'b1;

endpackage

// File: rtl/rotator_ctrl_debouncer.sv
// Debouncer: 2-flop synchroniser + 4-state debounce FSM with a DB_N-bit window counter.
// Latency: raw rise before edge 1 gives db_tick after edge 3 + 2^DB_N, for one cycle.
// Backpressure: none; a press shorter than the full window is discarded.
module debouncer
  import rotator_pkg::*;
#(
  parameter int DB_N = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic db_level,
  output logic db_tick
);

  localparam logic [DB_N-1:0] CNT_MAX = '1;
  localparam logic [DB_N-1:0] CNT_ONE = {{(DB_N-1){1'b0}}, 1'b1};

  logic            s1_q;
  logic            s2_q;
  db_state_t       state_q, state_d;
  logic [DB_N-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;

  // Bring the asynchronous button into the clock domain; only s2 is trusted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sw;
      s2_q <= s1_q;
    end
  end

  // Debounce state, window counter and registered press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ZERO;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  // Next state: any disagreeing sample during a window falls back to the old level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    unique case (state_q)
      ZERO: begin
        if (s2_q) begin
          state_d = WAIT1;
          cnt_d   = CNT_MAX;
        end
      end
      WAIT1: begin
        if (!s2_q) begin
          state_d = ZERO;
        end else if (cnt_q == '0) begin
          state_d = ONE;
          tick_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ONE: begin
        if (!s2_q) begin
          state_d = WAIT0;
          cnt_d   = CNT_MAX;
        end
      end
      WAIT0: begin
        if (s2_q) begin
          state_d = ONE;
        end else if (cnt_q == '0) begin
          state_d = ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ZERO;
    endcase
  end

  assign db_level = (state_q == ONE) || (state_q == WAIT0);
  assign db_tick  = tick_q;

endmodule

// File: rtl/rotator_ctrl.sv
// Push-button front end: debounced run/dir presses toggle the rotator en/cw controls.
// Latency: toggle visible after edge 4 + 2^DB_N from a raw rise; ticks one cycle earlier.
// Backpressure: none. Optional status LEDs with ROTATOR_CTRL_LED_EN defined.
module rotator_ctrl
  import rotator_pkg::*;
#(
  parameter int DB_N = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_dir,
  output logic       en,
  output logic       cw,
  output logic       run_tick,
  output logic       dir_tick
`ifdef ROTATOR_CTRL_LED_EN
  ,
  output logic [1:0] led
`endif
);

  logic run_lvl, run_tck;
  logic dir_lvl, dir_tck;
  logic en_q, en_d;
  logic cw_q, cw_d;

  debouncer #(.DB_N(DB_N)) u_db_run (
    .clk      (clk),
    .rst      (rst),
    .sw       (btn_run),
    .db_level (run_lvl),
    .db_tick  (run_tck)
  );

  debouncer #(.DB_N(DB_N)) u_db_dir (
    .clk      (clk),
    .rst      (rst),
    .sw       (btn_dir),
    .db_level (dir_lvl),
    .db_tick  (dir_tck)
  );

  // Toggle on each press pulse; the pulse always coincides with the debounced-high level.
  always_comb begin
    en_d = en_q;
    cw_d = cw_q;
    if (run_tck && run_lvl) en_d = ~en_q;
    if (dir_tck && dir_lvl) cw_d = ~cw_q;
  end

  // Rotator control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= EN_RST;
      cw_q <= CW_RST;
    end else begin
      en_q <= en_d;
      cw_q <= cw_d;
    end
  end

`ifdef ROTATOR_CTRL_LED_EN
  logic [1:0] led_q;

  // Status LEDs track the same next-state so they change on the same edge as en/cw.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= {~CW_RST, EN_RST};
    end else begin
      led_q <= {~cw_d, en_d};
    end
  end

  assign led = led_q;
`endif

  assign en       = en_q;
  assign cw       = cw_q;
  assign run_tick = run_tck;
  assign dir_tick = dir_tck;

endmodule

// File: tb/tb_rotator_ctrl.sv
// Bench for rotator_ctrl with DB_N = 4: expected ticks/toggles queued at stimulus time.
// Inputs change 1 time unit after a rising edge; outputs sampled at the same point.
// Edge e of a scenario is the e-th rising edge after its first input change.
module tb_rotator_ctrl;

  localparam int DB_N = 4;
  localparam int WIN  = 3 + (1 << DB_N);  // raw rise to tick, in edges

  logic clk     = 1'b0;
  logic clk_en  = 1'b1;
  logic rst     = 1'b1;
  logic btn_run = 1'b0;
  logic btn_dir = 1'b0;
  logic en, cw, run_tick, dir_tick;
`ifdef ROTATOR_CTRL_LED_EN
  logic [1:0] led;
`endif

  int   checks   = 0;
  int   failures = 0;
  logic exp_en   = 1'b0;
  logic exp_cw   = 1'b1;
  int   run_q[$];
  int   dir_q[$];
  int   run_flip_q[$];
  int   dir_flip_q[$];

  always #5 if (clk_en) clk = ~clk;

  rotator_ctrl #(.DB_N(DB_N)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_run  (btn_run),
    .btn_dir  (btn_dir),
    .en       (en),
    .cw       (cw),
    .run_tick (run_tick),
    .dir_tick (dir_tick)
`ifdef ROTATOR_CTRL_LED_EN
    ,
    .led      (led)
`endif
  );

  task automatic test_reset();
    rst     = 1'b1;
    btn_run = 1'b0;
    btn_dir = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (en !== 1'b0) begin failures++; $display("FAIL reset.en got=%b exp=0", en); end
    checks++; if (cw !== 1'b1) begin failures++; $display("FAIL reset.cw got=%b exp=1", cw); end
    checks++; if (run_tick !== 1'b0) begin failures++; $display("FAIL reset.run_tick got=%b exp=0", run_tick); end
    checks++; if (dir_tick !== 1'b0) begin failures++; $display("FAIL reset.dir_tick got=%b exp=0", dir_tick); end
    rst = 1'b0;
  endtask

  // Press 40, release 40, press 40, release 40.
  task automatic test_run_toggle();
    run_q.push_back(WIN);      run_flip_q.push_back(WIN + 1);
    run_q.push_back(80 + WIN); run_flip_q.push_back(80 + WIN + 1);
    for (int e = 1; e <= 160; e++) begin
      logic exp_rt;
      btn_run = (((e - 1) / 40) % 2 == 0);
      @(posedge clk); #1;
      exp_rt = (run_q.size() != 0 && run_q[0] == e);
      if (exp_rt) void'(run_q.pop_front());
      if (run_flip_q.size() != 0 && run_flip_q[0] == e) begin
        void'(run_flip_q.pop_front());
        exp_en = ~exp_en;
      end
      checks++; if (run_tick !== exp_rt) begin failures++; $display("FAIL run_toggle.run_tick edge=%0d got=%b exp=%b", e, run_tick, exp_rt); end
      checks++; if (en !== exp_en) begin failures++; $display("FAIL run_toggle.en edge=%0d got=%b exp=%b", e, en, exp_en); end
      checks++; if (dir_tick !== 1'b0) begin failures++; $display("FAIL run_toggle.dir_tick edge=%0d got=%b exp=0", e, dir_tick); end
      checks++; if (cw !== exp_cw) begin failures++; $display("FAIL run_toggle.cw edge=%0d got=%b exp=%b", e, cw, exp_cw); end
    end
    checks++; if (run_q.size() != 0) begin failures++; $display("FAIL run_toggle.missing_ticks got=%0d exp=0", run_q.size()); end
  endtask

  // A 10-cycle press is shorter than the window: no tick, cw unchanged.
  task automatic test_dir_glitch();
    for (int e = 1; e <= 40; e++) begin
      btn_dir = (e <= 10);
      @(posedge clk); #1;
      checks++; if (dir_tick !== 1'b0) begin failures++; $display("FAIL dir_glitch.dir_tick edge=%0d got=%b exp=0", e, dir_tick); end
      checks++; if (cw !== exp_cw) begin failures++; $display("FAIL dir_glitch.cw edge=%0d got=%b exp=%b", e, cw, exp_cw); end
      checks++; if (run_tick !== 1'b0) begin failures++; $display("FAIL dir_glitch.run_tick edge=%0d got=%b exp=0", e, run_tick); end
      checks++; if (en !== exp_en) begin failures++; $display("FAIL dir_glitch.en edge=%0d got=%b exp=%b", e, en, exp_en); end
    end
  endtask

  // Both buttons rise together: both toggles land on the same edge.
  task automatic test_simultaneous();
    run_q.push_back(WIN); run_flip_q.push_back(WIN + 1);
    dir_q.push_back(WIN); dir_flip_q.push_back(WIN + 1);
    for (int e = 1; e <= 80; e++) begin
      logic exp_rt, exp_dt;
      btn_run = (e <= 40);
      btn_dir = (e <= 40);
      @(posedge clk); #1;
      exp_rt = (run_q.size() != 0 && run_q[0] == e);
      if (exp_rt) void'(run_q.pop_front());
      exp_dt = (dir_q.size() != 0 && dir_q[0] == e);
      if (exp_dt) void'(dir_q.pop_front());
      if (run_flip_q.size() != 0 && run_flip_q[0] == e) begin
        void'(run_flip_q.pop_front());
        exp_en = ~exp_en;
      end
      if (dir_flip_q.size() != 0 && dir_flip_q[0] == e) begin
        void'(dir_flip_q.pop_front());
        exp_cw = ~exp_cw;
      end
      checks++; if (run_tick !== exp_rt) begin failures++; $display("FAIL simul.run_tick edge=%0d got=%b exp=%b", e, run_tick, exp_rt); end
      checks++; if (dir_tick !== exp_dt) begin failures++; $display("FAIL simul.dir_tick edge=%0d got=%b exp=%b", e, dir_tick, exp_dt); end
      checks++; if (en !== exp_en) begin failures++; $display("FAIL simul.en edge=%0d got=%b exp=%b", e, en, exp_en); end
      checks++; if (cw !== exp_cw) begin failures++; $display("FAIL simul.cw edge=%0d got=%b exp=%b", e, cw, exp_cw); end
    end
    checks++; if (run_q.size() + dir_q.size() != 0) begin failures++; $display("FAIL simul.missing_ticks got=%0d exp=0", run_q.size() + dir_q.size()); end
  endtask

  // Reset with the clock stopped must clear en/cw without any edge.
  task automatic test_async_reset();
    checks++; if (en !== exp_en || cw !== exp_cw) begin failures++; $display("FAIL async_rst.pre got=%b%b exp=%b%b", en, cw, exp_en, exp_cw); end
    @(negedge clk);
    clk_en = 1'b0;
    #3;
    rst = 1'b1;
    #2;
    exp_en = 1'b0;
    exp_cw = 1'b1;
    checks++; if (clk !== 1'b0) begin failures++; $display("FAIL async_rst.clk_stopped got=%b exp=0", clk); end
    checks++; if (en !== exp_en) begin failures++; $display("FAIL async_rst.en got=%b exp=%b", en, exp_en); end
    checks++; if (cw !== exp_cw) begin failures++; $display("FAIL async_rst.cw got=%b exp=%b", cw, exp_cw); end
    #5;
    rst = 1'b0;
    clk_en = 1'b1;
    @(posedge clk); #1;
  endtask

  // Bounce 3 high / 3 low for 24 cycles, then hold: one tick WIN edges after the final rise.
  task automatic test_bounce();
    run_q.push_back(24 + WIN); run_flip_q.push_back(24 + WIN + 1);
    for (int e = 1; e <= 110; e++) begin
      logic exp_rt;
      if (e <= 24) btn_run = (((e - 1) / 3) % 2 == 0);
      else         btn_run = (e <= 70);
      @(posedge clk); #1;
      exp_rt = (run_q.size() != 0 && run_q[0] == e);
      if (exp_rt) void'(run_q.pop_front());
      if (run_flip_q.size() != 0 && run_flip_q[0] == e) begin
        void'(run_flip_q.pop_front());
        exp_en = ~exp_en;
      end
      checks++; if (run_tick !== exp_rt) begin failures++; $display("FAIL bounce.run_tick edge=%0d got=%b exp=%b", e, run_tick, exp_rt); end
      checks++; if (en !== exp_en) begin failures++; $display("FAIL bounce.en edge=%0d got=%b exp=%b", e, en, exp_en); end
      checks++; if (cw !== exp_cw) begin failures++; $display("FAIL bounce.cw edge=%0d got=%b exp=%b", e, cw, exp_cw); end
    end
    checks++; if (run_q.size() != 0) begin failures++; $display("FAIL bounce.missing_ticks got=%0d exp=0", run_q.size()); end
  endtask

  // Reset 10 cycles into a held press; the full window restarts after deassert.
  task automatic test_reset_mid_press();
    for (int e = 1; e <= 10; e++) begin
      btn_run = 1'b1;
      @(posedge clk); #1;
      checks++; if (run_tick !== 1'b0) begin failures++; $display("FAIL mid_rst.pre_tick edge=%0d got=%b exp=0", e, run_tick); end
      checks++; if (en !== exp_en) begin failures++; $display("FAIL mid_rst.pre_en edge=%0d got=%b exp=%b", e, en, exp_en); end
    end
    rst = 1'b1;
    #1;
    exp_en = 1'b0;
    exp_cw = 1'b1;
    checks++; if (en !== exp_en) begin failures++; $display("FAIL mid_rst.en got=%b exp=%b", en, exp_en); end
    checks++; if (cw !== exp_cw) begin failures++; $display("FAIL mid_rst.cw got=%b exp=%b", cw, exp_cw); end
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    run_q.push_back(WIN); run_flip_q.push_back(WIN + 1);
    for (int e = 1; e <= 80; e++) begin
      logic exp_rt;
      btn_run = (e <= 40);
      @(posedge clk); #1;
      exp_rt = (run_q.size() != 0 && run_q[0] == e);
      if (exp_rt) void'(run_q.pop_front());
      if (run_flip_q.size() != 0 && run_flip_q[0] == e) begin
        void'(run_flip_q.pop_front());
        exp_en = ~exp_en;
      end
      checks++; if (run_tick !== exp_rt) begin failures++; $display("FAIL mid_rst.run_tick edge=%0d got=%b exp=%b", e, run_tick, exp_rt); end
      checks++; if (en !== exp_en) begin failures++; $display("FAIL mid_rst.en_after edge=%0d got=%b exp=%b", e, en, exp_en); end
      checks++; if (cw !== exp_cw) begin failures++; $display("FAIL mid_rst.cw_after edge=%0d got=%b exp=%b", e, cw, exp_cw); end
    end
    checks++; if (run_q.size() != 0) begin failures++; $display("FAIL mid_rst.missing_ticks got=%0d exp=0", run_q.size()); end
  endtask

  initial begin
    test_reset();
    test_run_toggle();
    test_dir_glitch();
    test_simultaneous();
    test_async_reset();
    test_bounce();
    test_reset_mid_press();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
